// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared definitions for the two-requester burst arbiter.
//   - state_e        : arbiter FSM state encoding
//   - DefaultDataW   : default data word width
//   - DefaultBurstMax: default max transfers per grant (legal 1..15)
//   - sat_inc8       : 8-bit saturating increment (grant statistics)
package mux_arbiter_pkg;

    localparam int unsigned DefaultDataW    = 7;
    localparam int unsigned DefaultBurstMax = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StServeA = 2'd1,
        StServeB = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mux_arbiter_out_reg.sv
// mux_arbiter_out_reg: single-entry output register with valid/ready handshake.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   load              - capture data/src this cycle (sets out_valid)
//   data, src         - word and source tag to capture
//   out_ready         - downstream ready
//   out_valid         - register holds a word
//   out_data, out_src - held word and its source (0=A, 1=B)
module mux_arbiter_out_reg
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              src,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (load) begin
            // The load takes priority so a drain and a refill in the same cycle leave no bubble.
            out_valid <= 1'b1;
            out_data  <= data;
            out_src   <= src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter with bounded bursts and a
// registered output stage.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   a_valid, a_data, a_ready  - requester A handshake
//   b_valid, b_data, b_ready  - requester B handshake
//   out_valid, out_data,
//   out_src, out_ready        - downstream handshake (out_src 0=A, 1=B)
//   busy                      - high whenever a grant is active
//   a_grants, b_grants        - saturating accepted-transfer counters, present
//                               only when MUX_ARBITER_STATS_EN is defined
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned BURST_MAX = DefaultBurstMax
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              busy,
    input  logic              out_ready
`ifdef MUX_ARBITER_STATS_EN
    ,
    output logic [7:0]        a_grants,
    output logic [7:0]        b_grants
`endif
);

    localparam logic [3:0] LastCnt = 4'(BURST_MAX - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rr_q, rr_d;  // requester granted last: 0=A, 1=B

    logic can_load;
    logic a_xfer, b_xfer;

    assign can_load = !out_valid || out_ready;
    assign a_ready  = (state_q == StServeA) && can_load;
    assign b_ready  = (state_q == StServeB) && can_load;
    assign a_xfer   = a_valid && a_ready;
    assign b_xfer   = b_valid && b_ready;
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                // Tie goes to A only if B was granted last.
                if (a_valid && (!b_valid || rr_q)) begin
                    state_d = StServeA;
                    cnt_d   = 4'd0;
                    rr_d    = 1'b0;
                end else if (b_valid) begin
                    state_d = StServeB;
                    cnt_d   = 4'd0;
                    rr_d    = 1'b1;
                end
            end
            StServeA: begin
                if (!a_valid || (a_xfer && cnt_q == LastCnt)) begin
                    if (b_valid) begin
                        state_d = StServeB;
                        cnt_d   = 4'd0;
                        rr_d    = 1'b1;
                    end else if (a_valid) begin
                        cnt_d = 4'd0;
                        rr_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (a_xfer) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StServeB: begin
                if (!b_valid || (b_xfer && cnt_q == LastCnt)) begin
                    if (a_valid) begin
                        state_d = StServeA;
                        cnt_d   = 4'd0;
                        rr_d    = 1'b0;
                    end else if (b_valid) begin
                        cnt_d = 4'd0;
                        rr_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (b_xfer) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    mux_arbiter_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (a_xfer || b_xfer),
        .data      (b_xfer ? b_data : a_data),
        .src       (b_xfer),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src)
    );

`ifdef MUX_ARBITER_STATS_EN
    logic [7:0] a_grants_q, b_grants_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_grants_q <= 8'd0;
            b_grants_q <= 8'd0;
        end else begin
            if (a_xfer) a_grants_q <= sat_inc8(a_grants_q);
            if (b_xfer) b_grants_q <= sat_inc8(b_grants_q);
        end
    end

    assign a_grants = a_grants_q;
    assign b_grants = b_grants_q;
`endif

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 7, width of each requester's data word.
REQ-002 SHALL have parameter BURST_MAX, default 4, max transfers per grant (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports a_valid input 1, a_data input DATA_W, a_ready output 1: requester A handshake.
REQ-006 SHALL have ports b_valid input 1, b_data input DATA_W, b_ready output 1: requester B handshake.
REQ-007 SHALL have ports out_valid output 1, out_data output DATA_W, out_src output 1 (0=A, 1=B), out_ready input 1: downstream handshake.
REQ-008 SHALL have port busy  output 1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, SERVE_A, SERVE_B.
REQ-010 Transfer SHALL occur on a requester side in a cycle where its valid and ready are both high; downstream transfer when out_valid and out_ready are both high.
REQ-011 a_ready SHALL be high only in SERVE_A with (!out_valid or out_ready); b_ready likewise in SERVE_B; both low in IDLE.
REQ-012 Accepted word SHALL appear on out_data/out_src with out_valid high the next cycle (latency 1); out_data/out_src held stable while out_valid and !out_ready.
REQ-013 out_valid SHALL clear after a downstream transfer with no new requester transfer in the same cycle; simultaneous downstream and requester transfer SHALL reload without a bubble.
REQ-014 IDLE: if exactly one valid, go to its SERVE state; if both, go to the requester not served last (round-robin pointer); if none, stay. IDLE costs one bubble cycle.
REQ-015 A 4-bit burst counter SHALL count transfers in the current grant, cleared on every grant entry.
REQ-016 Grant SHALL end in a cycle where the granted valid is low, or a transfer occurs with counter == BURST_MAX-1.
REQ-017 On grant end: other requester valid -> SERVE_other; else granted valid still high -> same SERVE state, counter cleared; else IDLE.
REQ-018 Round-robin pointer SHALL update to the granted requester on each grant entry.
REQ-019 Requester valid dropping without transfer SHALL not corrupt out_data; no word SHALL be duplicated or lost.

Reset
REQ-020 While rst high: state IDLE, counter 0, pointer = B (A wins first tie), out_valid 0, out_data 0, out_src 0, a_ready 0, b_ready 0, busy 0.
REQ-021 Reset asserted mid-burst SHALL discard the in-flight output word immediately (asynchronous).

Configuration
REQ-022 Macro MUX_ARBITER_STATS_EN defined: SHALL add outputs a_grants, b_grants (8 bits each) counting accepted transfers per requester, saturating at 255, reset to 0.
REQ-023 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-024 Package mux_arbiter_pkg SHALL hold the FSM state enum, the default DATA_W and BURST_MAX constants.
REQ-025 Output register stage SHALL be sub-module mux_arbiter_out_reg (load, data, src, out handshake).

Verification
REQ-026 Reset, then a_valid only, a_data=7'h15, out_ready=1 -> IDLE one cycle, a_ready high cycle 2, out_data=7'h15 out_src=0 cycle 3.
REQ-027 Both valid continuously, out_ready=1, BURST_MAX=4 -> 4 A words, then 4 B words, alternating; A first after reset.
REQ-028 Only A valid for 10 words, BURST_MAX=4 -> grant retained (counter clears at 4, 8), no bubble after IDLE exit.
REQ-029 SERVE_B, out_ready=0 for 5 cycles -> b_ready low, out_data held, no word lost; release -> stream resumes in order.
REQ-030 rst pulse mid-burst -> out_valid, readies, busy low same cycle; post-reset tie grants A; with MUX_ARBITER_STATS_EN, 300 A transfers -> a_grants=255.
